// File: rtl/board_scan_reader_if.sv
// Row read port and renderer cell stream shared by board_scan_reader and
// its neighbours. master = the scan reader, slave = board store + renderer.
interface board_scan_reader_if #(
   parameter int COLS = 10
);
   logic            row_rd;
   logic [4:0]      row_addr;
   logic [COLS-1:0] row_data;
   logic            cell_valid;
   logic            cell_ready;
   logic [3:0]      cell_x;
   logic [4:0]      cell_y;
   logic            cell_on;
   logic            cell_piece;

   modport master (
      output row_rd, row_addr,
      input  row_data,
      output cell_valid, cell_x, cell_y, cell_on, cell_piece,
      input  cell_ready
   );

   modport slave (
      input  row_rd, row_addr,
      output row_data,
      input  cell_valid, cell_x, cell_y, cell_on, cell_piece,
      output cell_ready
   );
endinterface

// File: rtl/board_scan_reader.sv
// Frame-synchronous board scanner: on each vs rising edge it reads the board
// top row first through a one-cycle-latency row port and streams every cell
// to the renderer over valid/ready.
// Optional macro BOARD_SCAN_OVERLAY_EN merges the falling piece (snapshotted
// at scan start) into the stream; undefined, cell_piece is tied low.
module board_scan_reader #(
   parameter int ROWS = 20,
   parameter int COLS = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                vs,
   input  logic [4:0]          x0, x1, x2, x3,
   input  logic [5:0]          y0, y1, y2, y3,
   board_scan_reader_if.master bus,
   output logic                busy,
   output logic                frame_done,
   output logic                overrun
);
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

   state_t          state, state_nx;
   logic            vs_q, start, accept, xfer, last_col, emit;
   logic            row_rd_c, cell_valid_c, piece;
   logic [4:0]      row;
   logic [3:0]      col;
   logic [COLS-1:0] rowreg;

   assign start    = vs & ~vs_q;
   assign accept   = start & (state == IDLE);
   assign emit     = (state == EMIT);
   assign xfer     = emit & bus.cell_ready;
   assign last_col = (col == 4'(COLS - 1));

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // next state and control strobes; cell_valid depends on state only
   always_comb begin
      state_nx     = state;
      row_rd_c     = 1'b0;
      cell_valid_c = 1'b0;
      frame_done   = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: begin
            row_rd_c = 1'b1;
            state_nx = WAIT;
         end
         WAIT:  state_nx = EMIT;
         EMIT:  begin
            cell_valid_c = 1'b1;
            if (xfer && last_col) state_nx = (row == 5'd0) ? DONE : FETCH;
         end
         DONE:  begin
            frame_done = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // vs edge detect, row/col counters, row capture, overrun flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_q    <= 1'b0;
         row     <= '0;
         col     <= '0;
         rowreg  <= '0;
         overrun <= 1'b0;
      end else begin
         vs_q <= vs;
         // an accepted start clears the flag, a start while busy sets it
         if (start) overrun <= (state != IDLE);
         if (accept)                               row <= 5'(ROWS - 1);
         else if (xfer && last_col && row != 5'd0) row <= row - 5'd1;
         if (state == WAIT) begin
            rowreg <= bus.row_data;
            col    <= '0;
         end else if (xfer && !last_col) begin
            col <= col + 4'd1;
         end
      end
   end

`ifdef BOARD_SCAN_OVERLAY_EN
   logic [3:0][4:0] px;
   logic [3:0][5:0] py;
   logic [3:0]      hit;

   // piece snapshot so a mid-frame move cannot tear the displayed piece
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         px <= '0;
         py <= '0;
      end else if (accept) begin
         px <= {x3, x2, x1, x0};
         py <= {y3, y2, y1, y0};
      end
   end

   // out-of-board coordinates are rejected explicitly, never aliased
   for (genvar i = 0; i < 4; i++) begin : g_hit
      assign hit[i] = (px[i] < 5'(COLS)) && (py[i] < 6'(ROWS)) &&
                      (px[i] == {1'b0, col}) && (py[i] == {1'b0, row});
   end
   assign piece = emit & (|hit);
`else
   logic unused_piece;
   assign unused_piece = ^{x0, x1, x2, x3, y0, y1, y2, y3};
   assign piece        = 1'b0;
`endif

   assign busy           = (state != IDLE);
   assign bus.row_rd     = row_rd_c;
   assign bus.row_addr   = row_rd_c ? row : 5'd0;
   assign bus.cell_valid = cell_valid_c;
   assign bus.cell_x     = emit ? col : 4'd0;
   assign bus.cell_y     = emit ? row : 5'd0;
   assign bus.cell_on    = emit & (rowreg[col] | piece);
   assign bus.cell_piece = piece;
endmodule

// File: tb/tb_board_scan_reader.sv
// Directed bench for board_scan_reader: board RAM model, negedge monitor
// logging row reads / transfers / frame_done by cycle offset from the vs edge.
module tb_board_scan_reader;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       vs = 1'b0;
   logic [4:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
   logic [5:0] y0 = '0, y1 = '0, y2 = '0, y3 = '0;
   logic       busy, frame_done, overrun;

   board_scan_reader_if #(.COLS(10)) bus ();

   board_scan_reader #(.ROWS(20), .COLS(10)) dut (
      .clk(clk), .reset(reset), .vs(vs),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .bus(bus),
      .busy(busy), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y; bit on; bit piece; int off;} xfer_t;

   logic [9:0] board [0:19];
   int         cyc = 0;
   int         vs_cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   int         rd_q[$];
   int         rdc_q[$];
   int         done_q[$];
   xfer_t      xq[$];
   int         stall_bad = 0;
   int         rd_bad = 0;
   logic       p_valid = 1'b0;
   logic       p_ready = 1'b0;
   logic [10:0] p_pay = '0;

   // board store: one-cycle read latency
   always @(posedge clk) bus.row_data <= bus.row_rd ? board[bus.row_addr] : 10'd0;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.row_rd) begin
         rd_q.push_back(int'(bus.row_addr));
         rdc_q.push_back(cyc - vs_cyc);
         if (bus.cell_valid || (p_valid && !p_ready)) rd_bad <= rd_bad + 1;
      end
      if (bus.cell_valid && bus.cell_ready)
         xq.push_back('{int'(bus.cell_x), int'(bus.cell_y), bus.cell_on, bus.cell_piece, cyc - vs_cyc});
      if (frame_done) done_q.push_back(cyc - vs_cyc);
      if (p_valid && !p_ready &&
          (!bus.cell_valid || {bus.cell_x, bus.cell_y, bus.cell_on, bus.cell_piece} != p_pay))
         stall_bad <= stall_bad + 1;
      p_valid <= bus.cell_valid;
      p_ready <= bus.cell_ready;
      p_pay   <= {bus.cell_x, bus.cell_y, bus.cell_on, bus.cell_piece};
   end

   task automatic clear_log();
      rd_q.delete(); rdc_q.delete(); done_q.delete(); xq.delete();
      stall_bad = 0; rd_bad = 0;
   endtask

   task automatic pulse_vs();
      @(posedge clk); #1;
      vs = 1'b1;
      vs_cyc = cyc;
   endtask

   // run until frame_done (bounded); optional second vs edge at offset second_at
   task automatic run_scan(input bit rnd, input int second_at);
      int n = 0;
      while (done_q.size() == 0 && n < 1500) begin
         @(posedge clk); #1; n++;
         if (cyc - vs_cyc == 3) vs = 1'b0;
         if (second_at > 0 && cyc - vs_cyc == second_at - 1) vs = 1'b1;
         if (second_at > 0 && cyc - vs_cyc == second_at + 2) vs = 1'b0;
         bus.cell_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.cell_ready = 1'b1;
      vs = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      logic [20:0] outs;
      bus.cell_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      outs = {bus.row_rd, bus.cell_valid, busy, frame_done, overrun, bus.cell_x,
              bus.cell_y, bus.cell_on, bus.cell_piece, bus.row_addr};
      vectors++;
      if (outs !== 21'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", outs); end
      reset = 1'b1;
      bus.cell_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_empty();
      int bad = 0, on = 0, pc = 0;
      for (int i = 0; i < 20; i++) board[i] = 10'd0;
      clear_log();
      pulse_vs();
      run_scan(1'b0, 0);
      vectors++;
      if (rd_q.size() != 20) begin miscompares++; $display("FAIL empty_rd_count: got %0d want 20", rd_q.size()); end
      for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != 19 - i) bad++;
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL empty_rd_addr_order: got %0d wrong want 0", bad); end
      vectors++;
      if ((rdc_q.size() > 0 ? rdc_q[0] : -1) != 1) begin miscompares++; $display("FAIL empty_first_rd_cycle: got %0d want 1", rdc_q.size() > 0 ? rdc_q[0] : -1); end
      vectors++;
      if (xq.size() != 200) begin miscompares++; $display("FAIL empty_xfer_count: got %0d want 200", xq.size()); end
      bad = 0;
      foreach (xq[i]) begin
         if (xq[i].on) on++;
         if (xq[i].piece) pc++;
         if (xq[i].x != i % 10 || xq[i].y != 19 - i / 10) bad++;
      end
      vectors++;
      if (on != 0) begin miscompares++; $display("FAIL empty_cells_on: got %0d want 0", on); end
      vectors++;
      if (pc != 0) begin miscompares++; $display("FAIL empty_cells_piece: got %0d want 0", pc); end
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL empty_coord_order: got %0d wrong want 0", bad); end
      vectors++;
      if ((xq.size() > 0 ? xq[0].off : -1) != 3 || (xq.size() > 0 ? xq[xq.size()-1].off : -1) != 240) begin
         miscompares++;
         $display("FAIL empty_cell_window: got %0d..%0d want 3..240",
                  xq.size() > 0 ? xq[0].off : -1, xq.size() > 0 ? xq[xq.size()-1].off : -1);
      end
      vectors++;
      if (done_q.size() != 1 || (done_q.size() > 0 ? done_q[0] : -1) != 241) begin
         miscompares++;
         $display("FAIL empty_frame_done: got count %0d at %0d want 1 at 241",
                  done_q.size(), done_q.size() > 0 ? done_q[0] : -1);
      end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_pattern();
      int on = 0, r0 = 0;
      for (int i = 0; i < 20; i++) board[i] = 10'd0;
      board[0]  = 10'b1111111111;
      board[19] = 10'b0000000001;
      clear_log();
      pulse_vs();
      run_scan(1'b0, 0);
      vectors++;
      if (xq.size() != 200) begin miscompares++; $display("FAIL pat_xfer_count: got %0d want 200", xq.size()); end
      if (xq.size() == 200) begin
         vectors++;
         if (xq[0].x != 0 || xq[0].y != 19 || xq[0].on != 1'b1) begin
            miscompares++; $display("FAIL pat_first: got x%0d y%0d on%0d want x0 y19 on1", xq[0].x, xq[0].y, xq[0].on);
         end
         vectors++;
         if (xq[1].x != 1 || xq[1].y != 19 || xq[1].on != 1'b0) begin
            miscompares++; $display("FAIL pat_second: got x%0d y%0d on%0d want x1 y19 on0", xq[1].x, xq[1].y, xq[1].on);
         end
         for (int i = 190; i < 200; i++) if (xq[i].on && xq[i].y == 0) r0++;
         foreach (xq[i]) if (xq[i].on) on++;
         vectors++;
         if (r0 != 10) begin miscompares++; $display("FAIL pat_row0_on: got %0d want 10", r0); end
         vectors++;
         if (on != 11) begin miscompares++; $display("FAIL pat_total_on: got %0d want 11", on); end
      end
   endtask

   task automatic test_stalls();
      int bad = 0;
      for (int i = 0; i < 20; i++) board[i] = 10'((i * 37 + 5) * 13);
      clear_log();
      pulse_vs();
      run_scan(1'b1, 0);
      vectors++;
      if (xq.size() != 200) begin miscompares++; $display("FAIL stall_xfer_count: got %0d want 200", xq.size()); end
      foreach (xq[i]) if (xq[i].on != board[xq[i].y][xq[i].x]) bad++;
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL stall_cell_on: got %0d wrong want 0", bad); end
      vectors++;
      if (stall_bad != 0) begin miscompares++; $display("FAIL stall_payload_stable: got %0d changes want 0", stall_bad); end
      vectors++;
      if (rd_bad != 0 || rd_q.size() != 20) begin
         miscompares++; $display("FAIL stall_row_rd: got %0d bad, %0d reads want 0, 20", rd_bad, rd_q.size());
      end
      vectors++;
      if (done_q.size() != 1) begin miscompares++; $display("FAIL stall_frame_done: got %0d want 1", done_q.size()); end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 20; i++) board[i] = 10'd0;
      clear_log();
      pulse_vs();
      run_scan(1'b0, 50);
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b want 1", overrun); end
      vectors++;
      if (xq.size() != 200 || rd_q.size() != 20) begin
         miscompares++; $display("FAIL ovr_scan_intact: got %0d xfers %0d reads want 200, 20", xq.size(), rd_q.size());
      end
      vectors++;
      if (done_q.size() != 1 || (done_q.size() > 0 ? done_q[0] : -1) != 241) begin
         miscompares++; $display("FAIL ovr_frame_done: got count %0d at %0d want 1 at 241",
                                 done_q.size(), done_q.size() > 0 ? done_q[0] : -1);
      end
      clear_log();
      pulse_vs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      vectors++;
      if (overrun !== 1'b0 || busy !== 1'b1) begin
         miscompares++; $display("FAIL ovr_clear: got overrun %b busy %b want 0 1", overrun, busy);
      end
      run_scan(1'b0, 0);
   endtask

   task automatic test_reset_mid();
      logic [20:0] outs;
      int n = 0;
      for (int i = 0; i < 20; i++) board[i] = 10'h3FF;
      clear_log();
      pulse_vs();
      while (cyc - vs_cyc < 100 && n < 200) begin
         @(posedge clk); #1; n++;
         if (cyc - vs_cyc == 3) vs = 1'b0;
      end
      vectors++;
      if (bus.cell_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_active: got valid %b want 1", bus.cell_valid); end
      #2 reset = 1'b0;
      #1;
      outs = {bus.row_rd, bus.cell_valid, busy, frame_done, overrun, bus.cell_x,
              bus.cell_y, bus.cell_on, bus.cell_piece, bus.row_addr};
      vectors++;
      if (outs !== 21'd0) begin miscompares++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (250) begin @(posedge clk); #1; end
      vectors++;
      if (done_q.size() != 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d want 0", done_q.size()); end
      clear_log();
      pulse_vs();
      run_scan(1'b0, 0);
      vectors++;
      if ((rd_q.size() > 0 ? rd_q[0] : -1) != 19 || xq.size() != 200 || done_q.size() != 1) begin
         miscompares++; $display("FAIL rstmid_restart: got addr %0d xfers %0d done %0d want 19 200 1",
                                 rd_q.size() > 0 ? rd_q[0] : -1, xq.size(), done_q.size());
      end
   endtask

`ifdef BOARD_SCAN_OVERLAY_EN
   task automatic test_overlay();
      int pc = 0, good = 0, n = 0;
      for (int i = 0; i < 20; i++) board[i] = 10'd0;
      x0 = 5'd4; y0 = 6'd19; x1 = 5'd5; y1 = 6'd19;
      x2 = 5'd4; y2 = 6'd18; x3 = 5'd5; y3 = 6'd18;
      clear_log();
      pulse_vs();
      while (cyc - vs_cyc < 60 && n < 100) begin
         @(posedge clk); #1; n++;
         if (cyc - vs_cyc == 3) vs = 1'b0;
      end
      x0 = 5'd0; y0 = 6'd0; x1 = 5'd1; y1 = 6'd1;
      x2 = 5'd2; y2 = 6'd2; x3 = 5'd3; y3 = 6'd3;
      run_scan(1'b0, 0);
      foreach (xq[i]) if (xq[i].piece) begin
         pc++;
         if (xq[i].on && (xq[i].x == 4 || xq[i].x == 5) && (xq[i].y == 19 || xq[i].y == 18)) good++;
      end
      vectors++;
      if (pc != 4 || good != 4) begin miscompares++; $display("FAIL ovl_piece: got %0d piece %0d good want 4 4", pc, good); end
      x0 = 5'd4; y0 = 6'd25; x1 = 5'd7; y1 = 6'd1;
      x2 = 5'd8; y2 = 6'd1;  x3 = 5'd9; y3 = 6'd1;
      clear_log();
      pulse_vs();
      run_scan(1'b0, 0);
      pc = 0;
      foreach (xq[i]) if (xq[i].piece && xq[i].on) pc++;
      vectors++;
      if (pc != 3) begin miscompares++; $display("FAIL ovl_y25: got %0d matches want 3", pc); end
   endtask
`endif

   initial begin
      bus.cell_ready = 1'b0;
      test_reset();
      test_empty();
      test_pattern();
      test_stalls();
      test_overrun();
      test_reset_mid();
`ifdef BOARD_SCAN_OVERLAY_EN
      test_overlay();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
